// File: rtl/carbon_sys16_bus_sched.sv
`default_nettype none
// ============================================================================
//  Module   : carbon_sys16_bus_sched
//  Purpose  : Two-master bus scheduler for SYS16-class systems. The CPU
//             (master 0) and CarbonDMA (master 1) share one target bus under
//             round-robin arbitration. An accepted request is decoded against
//             the SYS16 memory map to a target select code and sequenced
//             through the target handshake. The response is returned to the
//             granted master. A stalled target triggers a timeout error.
//  Ports    : clk, rst_n (async, active low)
//             m_req_valid/ready/addr/we/wdata : per-master request ({m1,m0})
//             m_rsp_valid/rdata/err           : response to the granted master
//             t_req_valid/ready/sel/addr/we/wdata : target request side
//             t_rsp_valid/rdata/err           : target response side
//  Revision : 1.0 - initial release
// ============================================================================
module carbon_sys16_bus_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ERR_RDATA      = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  m_req_valid,
    output logic [1:0]  m_req_ready,
    input  logic [31:0] m_req_addr,
    input  logic [1:0]  m_req_we,
    input  logic [15:0] m_req_wdata,
    output logic [1:0]  m_rsp_valid,
    output logic [7:0]  m_rsp_rdata,
    output logic        m_rsp_err,
    output logic        t_req_valid,
    input  logic        t_req_ready,
    output logic [3:0]  t_sel,
    output logic [15:0] t_req_addr,
    output logic        t_req_we,
    output logic [7:0]  t_req_wdata,
    input  logic        t_rsp_valid,
    input  logic [7:0]  t_rsp_rdata,
    input  logic        t_rsp_err
);

    // SYS16 memory map regions, checked in this order; the first hit wins.
    localparam logic [31:0] c_rom_base   = 32'h0000_0000, c_rom_mask   = 32'hFFFF_FF00;
    localparam logic [31:0] c_bdt_base   = 32'h0000_F800, c_bdt_mask   = 32'hFFFF_FF00;
    localparam logic [31:0] c_disc_base  = 32'h0000_F400, c_disc_mask  = 32'hFFFF_FF00;
    localparam logic [31:0] c_mmio_base  = 32'h0000_F000, c_mmio_mask  = 32'hFFFF_FF00;
    localparam logic [31:0] c_cio_base   = 32'h0000_F100, c_cio_mask   = 32'hFFFF_FF00;
    localparam logic [31:0] c_cdma_base  = 32'h0000_F200, c_cdma_mask  = 32'hFFFF_FF00;
    localparam logic [31:0] c_tier_base  = 32'h0000_F300, c_tier_mask  = 32'hFFFF_FF00;
    localparam logic [31:0] c_fsram_base = 32'h0000_8000, c_fsram_mask = 32'hFFFF_C000;
    localparam logic [15:0] c_timeout    = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;   // also identifies the master owning the transaction
    logic [15:0] r_cnt;
    logic [15:0] r_addr;
    logic        r_we;
    logic [7:0]  r_wdata;
    logic [3:0]  r_sel;
    logic [7:0]  r_rdata;
    logic        r_err;

    logic        w_any_req;
    logic        w_grant;
    logic [1:0]  w_req_ready;
    logic        w_timeout;
    logic [15:0] w_addr_sel;

    function automatic logic [3:0] f_decode(input logic [15:0] addr);
        logic [31:0] a;
        a = {16'h0000, addr};
        if      ((a & c_rom_mask)   == c_rom_base)   f_decode = 4'd0;
        else if ((a & c_bdt_mask)   == c_bdt_base)   f_decode = 4'd1;
        else if ((a & c_disc_mask)  == c_disc_base)  f_decode = 4'd2;
        else if ((a & c_mmio_mask)  == c_mmio_base)  f_decode = 4'd3;
        else if ((a & c_cio_mask)   == c_cio_base)   f_decode = 4'd4;
        else if ((a & c_cdma_mask)  == c_cdma_base)  f_decode = 4'd5;
        else if ((a & c_tier_mask)  == c_tier_base)  f_decode = 4'd6;
        else if ((a & c_fsram_mask) == c_fsram_base) f_decode = 4'd7;
        else                                         f_decode = 4'd8;
    endfunction

    assign w_any_req  = |m_req_valid;
    // Both valid: the master not served last time wins. One valid: it wins.
    assign w_grant    = (&m_req_valid) ? ~r_last_grant : ~m_req_valid[0];
    assign w_addr_sel = w_grant ? m_req_addr[31:16] : m_req_addr[15:0];
    assign w_timeout  = ((r_state == ISSUE) || (r_state == WAIT)) && (r_cnt == c_timeout);

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_req_ready[w_grant] = 1'b1;
                    w_state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                if (w_timeout)        w_state_nxt = RESP;
                else if (t_req_ready) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_timeout || t_rsp_valid) w_state_nxt = RESP;
            end
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The accept pulse is combinational on m_req_valid, so it is gated by
    // rst_n to keep every output low while reset is held.
    assign m_req_ready = w_req_ready & {2{rst_n}};
    assign t_req_valid = (r_state == ISSUE) && !w_timeout;
    assign m_rsp_valid = (r_state == RESP) ? (r_last_grant ? 2'b10 : 2'b01) : 2'b00;
    assign m_rsp_rdata = r_rdata;
    assign m_rsp_err   = r_err;
    assign t_sel       = r_sel;
    assign t_req_addr  = r_addr;
    assign t_req_we    = r_we;
    assign t_req_wdata = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= 16'd0;
            r_addr       <= 16'd0;
            r_we         <= 1'b0;
            r_wdata      <= 8'd0;
            r_sel        <= 4'd0;
            r_rdata      <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    r_cnt <= 16'd0;
                    if (w_any_req) begin
                        r_last_grant <= w_grant;
                        r_addr       <= w_addr_sel;
                        r_we         <= m_req_we[w_grant];
                        r_wdata      <= w_grant ? m_req_wdata[15:8] : m_req_wdata[7:0];
                        r_sel        <= f_decode(w_addr_sel);
                    end
                end
                ISSUE, WAIT: begin
                    if (w_timeout) begin
                        r_rdata <= ERR_RDATA;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if ((r_state == WAIT) && t_rsp_valid) begin
                            r_rdata <= t_rsp_rdata;
                            r_err   <= t_rsp_err;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_carbon_sys16_bus_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_carbon_sys16_bus_sched
//  Purpose  : Self-checking bench for carbon_sys16_bus_sched. Directed
//             scenarios with literal expectations, then randomized masters
//             and target compared every cycle against a transaction-level
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_carbon_sys16_bus_sched;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  m_req_valid = '0;
    logic [1:0]  m_req_ready;
    logic [31:0] m_req_addr = '0;
    logic [1:0]  m_req_we = '0;
    logic [15:0] m_req_wdata = '0;
    logic [1:0]  m_rsp_valid;
    logic [7:0]  m_rsp_rdata;
    logic        m_rsp_err;
    logic        t_req_valid;
    logic        t_req_ready = 1'b0;
    logic [3:0]  t_sel;
    logic [15:0] t_req_addr;
    logic        t_req_we;
    logic [7:0]  t_req_wdata;
    logic        t_rsp_valid = 1'b0;
    logic [7:0]  t_rsp_rdata = '0;
    logic        t_rsp_err = 1'b0;

    carbon_sys16_bus_sched #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_we(m_req_we), .m_req_wdata(m_req_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_sel(t_sel),
        .t_req_addr(t_req_addr), .t_req_we(t_req_we), .t_req_wdata(t_req_wdata),
        .t_rsp_valid(t_rsp_valid), .t_rsp_rdata(t_rsp_rdata), .t_rsp_err(t_rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (transaction level) ----------------
    // ph: 0 = free, 1 = request offered to target, 2 = awaiting response,
    //     3 = response being returned. age = cycles spent offered/awaiting.
    int          ph, owner, last, age;
    logic [15:0] e_addr;
    logic        e_we, e_err;
    logic [7:0]  e_wdata, e_rdata;
    logic [3:0]  e_sel;
    logic [1:0]  acc;

    // Memory map written as address ranges.
    function automatic logic [3:0] ref_sel(input logic [15:0] a);
        if (a <= 16'h00FF)                  return 4'd0;
        if (a >= 16'hF800 && a <= 16'hF8FF) return 4'd1;
        if (a >= 16'hF400 && a <= 16'hF4FF) return 4'd2;
        if (a >= 16'hF000 && a <= 16'hF0FF) return 4'd3;
        if (a >= 16'hF100 && a <= 16'hF1FF) return 4'd4;
        if (a >= 16'hF200 && a <= 16'hF2FF) return 4'd5;
        if (a >= 16'hF300 && a <= 16'hF3FF) return 4'd6;
        if (a >= 16'h8000 && a <= 16'hBFFF) return 4'd7;
        return 4'd8;
    endfunction

    function automatic int winner(input logic [1:0] v, input int lst);
        if (v == 2'b11) return 1 - lst;
        return v[0] ? 0 : 1;
    endfunction

    task automatic model_reset();
        ph = 0; owner = 0; last = 1; age = 0;
        e_addr = '0; e_we = 1'b0; e_wdata = '0; e_sel = '0; e_rdata = '0; e_err = 1'b0;
        acc = 2'b00;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp();
        logic [1:0] er;
        er = 2'b00;
        if (ph == 0 && m_req_valid != 2'b00) er[winner(m_req_valid, last)] = 1'b1;
        acc = er;
        chk("m_req_ready", {30'd0, m_req_ready}, {30'd0, er});
        chk("t_req_valid", {31'd0, t_req_valid}, {31'd0, (ph == 1 && age != TO)});
        chk("m_rsp_valid", {30'd0, m_rsp_valid}, (ph == 3) ? (32'd1 << owner) : 32'd0);
        chk("t_sel",       {28'd0, t_sel},       {28'd0, e_sel});
        chk("t_req_addr",  {16'd0, t_req_addr},  {16'd0, e_addr});
        chk("t_req_we",    {31'd0, t_req_we},    {31'd0, e_we});
        chk("t_req_wdata", {24'd0, t_req_wdata}, {24'd0, e_wdata});
        chk("m_rsp_rdata", {24'd0, m_rsp_rdata}, {24'd0, e_rdata});
        chk("m_rsp_err",   {31'd0, m_rsp_err},   {31'd0, e_err});
    endtask

    task automatic adv();
        int p;
        if (ph == 0) begin
            if (m_req_valid != 2'b00) begin
                p       = winner(m_req_valid, last);
                owner   = p; last = p; age = 0; ph = 1;
                e_addr  = m_req_addr[p*16 +: 16];
                e_we    = m_req_we[p];
                e_wdata = m_req_wdata[p*8 +: 8];
                e_sel   = ref_sel(e_addr);
            end
        end else if (ph == 1 || ph == 2) begin
            if (age == TO) begin
                e_rdata = 8'hFF; e_err = 1'b1; ph = 3;
            end else begin
                if (ph == 1 && t_req_ready) ph = 2;
                else if (ph == 2 && t_rsp_valid) begin
                    e_rdata = t_rsp_rdata; e_err = t_rsp_err; ph = 3;
                end
                age++;
            end
        end else begin
            ph = 0;
        end
    endtask

    // One clock: compare, advance the model, cross the edge, settle.
    task automatic tick();
        #2;
        cmp();
        adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_req_valid = 2'b00; t_req_ready = 1'b0; t_rsp_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic xact(input int m, input logic [15:0] a, input logic we, input logic [7:0] wd,
                        input logic [7:0] rd, input logic er, input logic [3:0] exp_sel);
        m_req_valid = 2'(1 << m);
        m_req_addr[m*16 +: 16] = a;
        m_req_we[m] = we;
        m_req_wdata[m*8 +: 8] = wd;
        t_req_ready = 1'b1; t_rsp_valid = 1'b1; t_rsp_rdata = rd; t_rsp_err = er;
        #1;
        chk("grant_ready", {30'd0, m_req_ready}, 32'd1 << m);
        tick();
        m_req_valid = 2'b00;
        #1;
        chk("issue_t_req_valid", {31'd0, t_req_valid}, 32'd1);
        chk("issue_t_sel", {28'd0, t_sel}, {28'd0, exp_sel});
        chk("issue_t_req_we", {31'd0, t_req_we}, {31'd0, we});
        tick();
        tick();
        #1;
        chk("rsp_valid", {30'd0, m_rsp_valid}, 32'd1 << m);
        chk("rsp_rdata", {24'd0, m_rsp_rdata}, {24'd0, rd});
        chk("rsp_err", {31'd0, m_rsp_err}, {31'd0, er});
        tick();
    endtask

    logic [15:0] addr_pool [12] = '{16'h0000, 16'h00FF, 16'h0100, 16'hF800, 16'hF8FF, 16'hF4FF,
                                    16'hF004, 16'hF1A0, 16'hF200, 16'hF3FF, 16'hBFFF, 16'hC000};

    initial begin
        int k;
        logic [1:0] seen [$];
        logic [1:0] pend;
        model_reset();

        // Reset values
        #1;
        chk("reset_outputs", {m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, t_req_valid,
                              t_sel, t_req_addr[7:0]}, 32'd0);
        do_reset();
        tick();

        // T1: m0 read from ROM, minimum latency
        xact(0, 16'h0010, 1'b0, 8'h00, 8'h3C, 1'b0, 4'd0);

        // T2: decode sweep
        xact(0, 16'hF800, 1'b0, 8'h00, 8'h11, 1'b0, 4'd1);
        xact(0, 16'hF4FF, 1'b0, 8'h00, 8'h22, 1'b0, 4'd2);
        xact(0, 16'hF004, 1'b1, 8'h5A, 8'h33, 1'b0, 4'd3);
        xact(0, 16'hF1A0, 1'b0, 8'h00, 8'h44, 1'b0, 4'd4);
        xact(0, 16'hF200, 1'b0, 8'h00, 8'h55, 1'b0, 4'd5);
        xact(0, 16'hF3FF, 1'b0, 8'h00, 8'h66, 1'b0, 4'd6);
        xact(0, 16'h8000, 1'b0, 8'h00, 8'h77, 1'b0, 4'd7);
        xact(0, 16'hBFFF, 1'b0, 8'h00, 8'h88, 1'b0, 4'd7);
        xact(0, 16'hC000, 1'b0, 8'h00, 8'h99, 1'b0, 4'd8);
        xact(0, 16'h0100, 1'b0, 8'h00, 8'hAA, 1'b0, 4'd8);

        // T5: m1 write to MMIO with target error
        xact(1, 16'hF008, 1'b1, 8'h41, 8'h00, 1'b1, 4'd3);

        // T3: both masters continuously valid -> alternating grants from reset
        do_reset();
        m_req_addr = {16'hC123, 16'h0042};
        t_req_ready = 1'b1; t_rsp_valid = 1'b1; t_rsp_rdata = 8'h5C; t_rsp_err = 1'b0;
        m_req_valid = 2'b11;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (m_req_ready != 2'b00) seen.push_back(m_req_ready);
            tick();
        end
        m_req_valid = 2'b00;
        chk("rr_grant_count", seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk("rr_grant_order", {30'd0, seen[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        repeat (4) tick();

        // T4: target never ready -> timeout
        do_reset();
        m_req_addr[15:0] = 16'h1234; m_req_we[0] = 1'b0;
        t_req_ready = 1'b0; t_rsp_valid = 1'b0;
        m_req_valid = 2'b01;
        tick();
        m_req_valid = 2'b00;
        k = 0;
        while (t_req_valid && k < 50) begin
            k++;
            tick();
        end
        chk("timeout_valid_cycles", k, TO);
        tick();
        #1;
        chk("timeout_rsp_valid", {30'd0, m_rsp_valid}, 32'd1);
        chk("timeout_rsp_err", {31'd0, m_rsp_err}, 32'd1);
        chk("timeout_rsp_rdata", {24'd0, m_rsp_rdata}, 32'hFF);
        tick();
        t_rsp_valid = 1'b1; t_rsp_rdata = 8'h12; t_rsp_err = 1'b0;
        tick();
        #1;
        chk("late_rsp_ignored", {30'd0, m_rsp_valid}, 32'd0);
        chk("late_rsp_rdata", {24'd0, m_rsp_rdata}, 32'hFF);
        t_rsp_valid = 1'b0;
        tick();

        // T6: reset during WAIT
        m_req_addr[15:0] = 16'hF1A0; t_req_ready = 1'b1; t_rsp_valid = 1'b0;
        m_req_valid = 2'b01;
        tick();
        m_req_valid = 2'b00;
        tick();  // now in WAIT
        m_req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err, t_req_valid,
                                    t_sel, t_req_we, t_req_wdata[6:0]}, 32'd0);
        chk("async_reset_addr", {16'd0, t_req_addr}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_first_grant", {30'd0, m_req_ready}, 32'd1);
        tick();
        m_req_valid = 2'b00;
        repeat (12) tick();

        // Randomized traffic
        do_reset();
        pend = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (acc[m]) pend[m] = 1'b0;
                if (!pend[m] && ($urandom % 3 == 0)) begin
                    pend[m] = 1'b1;
                    m_req_addr[m*16 +: 16] = ($urandom % 2 == 0) ? addr_pool[$urandom % 12]
                                                                  : 16'($urandom);
                    m_req_we[m] = 1'($urandom);
                    m_req_wdata[m*8 +: 8] = 8'($urandom);
                end
            end
            acc = 2'b00;
            m_req_valid = pend;
            t_req_ready = ($urandom % 4 == 0);
            t_rsp_valid = ($urandom % 4 == 0);
            t_rsp_rdata = 8'($urandom);
            t_rsp_err   = ($urandom % 5 == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
